// File: rtl/sp_issue_unit.sv
// rtl/sp_issue_unit.sv - single-lane issue/writeback sequencer with 16-entry register file
// Optional predicated writeback enabled by defining SP_ISSUE_PRED_EN.
module sp_issue_unit #(
    parameter int WIDTH  = 16,
    parameter int MAX_OP = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [3:0]       in_rd,
    input  logic [3:0]       in_ra,
    input  logic [3:0]       in_rb,
    input  logic [3:0]       in_rc,
    input  logic             in_pred,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_c,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_p,
    input  logic             host_we,
    input  logic [3:0]       host_addr,
    input  logic [WIDTH-1:0] host_data,
    input  logic [3:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             done,
    output logic             err,
    output logic             p_flag
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] MAX_OP_L = 4'(MAX_OP);

    state_t           state_q;
    logic             in_ready_q;
    logic [3:0]       op_q, rd_q, ra_q, rb_q, rc_q;
    logic             legal_q;
    logic             wb_en_q;
    logic [WIDTH-1:0] res_q;
    logic             resp_q;
    logic [WIDTH-1:0] rf_q [16];
    logic [WIDTH-1:0] alu_a_q, alu_b_q, alu_c_q;
    logic [3:0]       alu_ctrl_q;
    logic             done_q, err_q, p_flag_q;

    logic             wb_en_d;
    logic             rf_we_d;
    logic             p_we_d;

    // Predicate is resolved against p_flag as it stands when the instruction is accepted.
`ifdef SP_ISSUE_PRED_EN
    assign wb_en_d = !(in_pred && !p_flag_q);
`else
    logic unused_in_pred;
    assign unused_in_pred = in_pred;
    assign wb_en_d        = 1'b1;
`endif

    always_comb begin
        p_we_d  = 1'b0;
        rf_we_d = 1'b0;
        if (state_q == WB && legal_q && wb_en_q) begin
            p_we_d  = 1'b1;
            rf_we_d = (rd_q != 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            op_q       <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            legal_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            res_q      <= '0;
            resp_q     <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_c_q    <= '0;
            alu_ctrl_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            p_flag_q   <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Host write first so a same-cycle writeback to the same index overrides it.
            if (host_we && host_addr != 4'd0) rf_q[host_addr] <= host_data;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        rd_q       <= in_rd;
                        ra_q       <= in_ra;
                        rb_q       <= in_rb;
                        rc_q       <= in_rc;
                        legal_q    <= (in_op <= MAX_OP_L);
                        wb_en_q    <= wb_en_d;
                        in_ready_q <= 1'b0;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    alu_a_q    <= rf_q[ra_q];
                    alu_b_q    <= rf_q[rb_q];
                    alu_c_q    <= rf_q[rc_q];
                    alu_ctrl_q <= op_q;
                    state_q    <= EXEC;
                end
                EXEC: begin
                    res_q   <= alu_out;
                    resp_q  <= alu_p;
                    done_q  <= 1'b1;
                    err_q   <= !legal_q;
                    state_q <= WB;
                end
                WB: begin
                    if (rf_we_d) rf_q[rd_q] <= res_q;
                    if (p_we_d) p_flag_q <= resp_q;
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // R0 is never written, so it always reads as zero.
    assign dbg_data = rf_q[dbg_addr];
    assign in_ready = in_ready_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_c    = alu_c_q;
    assign alu_ctrl = alu_ctrl_q;
    assign done     = done_q;
    assign err      = err_q;
    assign p_flag   = p_flag_q;

endmodule

// File: tb/tb_sp_issue_unit.sv
// tb/tb_sp_issue_unit.sv - directed self-checking bench for sp_issue_unit
// Predication checks follow SP_ISSUE_PRED_EN when it is defined.
module tb_sp_issue_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op, in_rd, in_ra, in_rb, in_rc;
    logic        in_pred;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_p;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [15:0] host_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        done, err, p_flag;

    int checks = 0;
    int passed = 0;

    logic [15:0] ex_a, ex_b, ex_c;
    logic [3:0]  ex_ctrl;
    logic        err_seen;
    logic [15:0] rdata;
    int          lat;
    int          acc;

    always #5 clock = ~clock;

    sp_issue_unit #(.WIDTH(16), .MAX_OP(9)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_pred(in_pred),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_p(alu_p),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done(done), .err(err), .p_flag(p_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        host_we = 1'b1; host_addr = a; host_data = d;
        @(negedge clock);
        host_we = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Returns at the negedge after the WB cycle, when the writeback is visible.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] rc, input logic pred,
                         input logic [15:0] out, input logic p,
                         input logic hw, input logic [3:0] ha, input logic [15:0] hd,
                         output int latency);
        int n;
        @(negedge clock);
        in_op = op; in_rd = rd; in_ra = ra; in_rb = rb; in_rc = rc; in_pred = pred;
        alu_out = out; alu_p = p; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        latency = 0;
        err_seen = 1'b0;
        while (latency < 10) begin
            @(negedge clock);
            latency++;
            if (latency == 2) begin
                ex_a = alu_a; ex_b = alu_b; ex_c = alu_c; ex_ctrl = alu_ctrl;
            end
            if (done) begin
                err_seen = err;
                if (hw) begin
                    host_we = 1'b1; host_addr = ha; host_data = hd;
                end
                break;
            end
        end
        @(negedge clock);
        host_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_ra = '0; in_rb = '0;
        in_rc = '0; in_pred = 1'b0; alu_out = '0; alu_p = 1'b0; host_we = 1'b0;
        host_addr = '0; host_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_in_ready", in_ready, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_c", alu_c, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_p_flag", p_flag, 0);
        read_reg(4'd4, rdata);
        check("rst_r4", rdata, 0);

        host_write(4'd1, 16'h0019);
        host_write(4'd2, 16'h0002);
        host_write(4'd3, 16'h0005);
        read_reg(4'd3, rdata);
        check("host_r3", rdata, 16'h0005);
        issue(4'd4, 4'd4, 4'd1, 4'd2, 4'd3, 1'b0, 16'h00AB, 1'b1, 1'b0, 4'd0, 16'h0, lat);
        check("route_alu_a", ex_a, 16'h0019);
        check("route_alu_b", ex_b, 16'h0002);
        check("route_alu_c", ex_c, 16'h0005);
        check("route_alu_ctrl", ex_ctrl, 4'd4);
        check("route_latency", lat, 3);
        check("route_err", err_seen, 0);
        read_reg(4'd4, rdata);
        check("route_r4", rdata, 16'h00AB);
        check("route_p_flag", p_flag, 1);

        host_write(4'd5, 16'h1234);
        issue(4'd12, 4'd5, 4'd1, 4'd2, 4'd3, 1'b0, 16'hDEAD, 1'b0, 1'b0, 4'd0, 16'h0, lat);
        check("illegal_latency", lat, 3);
        check("illegal_err", err_seen, 1);
        read_reg(4'd5, rdata);
        check("illegal_r5", rdata, 16'h1234);
        check("illegal_p_flag", p_flag, 1);

        issue(4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 16'h0, lat);
        read_reg(4'd0, rdata);
        check("r0_wb_zero", rdata, 0);
        host_write(4'd0, 16'hAAAA);
        read_reg(4'd0, rdata);
        check("r0_host_zero", rdata, 0);

        issue(4'd2, 4'd6, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0001, 1'b1, 1'b1, 4'd6, 16'h5555, lat);
        read_reg(4'd6, rdata);
        check("collision_r6", rdata, 16'h0001);

        in_op = 4'd1; in_ra = 4'd1; in_rb = 4'd2; in_rc = 4'd3; in_pred = 1'b0;
        alu_out = 16'h0042; alu_p = 1'b1; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 9) in_valid = 1'b0;
            check($sformatf("b2b_ready_%0d", i), in_ready, (i % 4 == 0) ? 1 : 0);
            if (in_ready && in_valid) begin
                acc++;
                in_rd = 4'(8 + acc);
            end
        end
        in_valid = 1'b0;
        @(negedge clock);
        read_reg(4'd11, rdata);
        check("b2b_r11", rdata, 16'h0042);

        @(negedge clock);
        in_op = 4'd3; in_rd = 4'd7; alu_out = 16'h7777; alu_p = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_ctrl", alu_ctrl, 0);
        check("midrst_p_flag", p_flag, 0);
        reset = 1'b0;
        read_reg(4'd7, rdata);
        check("midrst_r7", rdata, 0);
        issue(4'd1, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0077, 1'b0, 1'b0, 4'd0, 16'h0, lat);
        check("midrst_next_latency", lat, 3);
        read_reg(4'd7, rdata);
        check("midrst_next_r7", rdata, 16'h0077);

`ifdef SP_ISSUE_PRED_EN
        issue(4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 1'b1, 16'h7777, 1'b0, 1'b0, 4'd0, 16'h0, lat);
        check("pred_skip_latency", lat, 3);
        read_reg(4'd8, rdata);
        check("pred_skip_r8", rdata, 0);
        issue(4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0003, 1'b1, 1'b0, 4'd0, 16'h0, lat);
        check("pred_set_p_flag", p_flag, 1);
        issue(4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 1'b1, 16'h7777, 1'b0, 1'b0, 4'd0, 16'h0, lat);
        read_reg(4'd8, rdata);
        check("pred_take_r8", rdata, 16'h7777);
`else
        issue(4'd1, 4'd8, 4'd0, 4'd0, 4'd0, 1'b1, 16'h7777, 1'b0, 1'b0, 4'd0, 16'h0, lat);
        read_reg(4'd8, rdata);
        check("nopred_r8", rdata, 16'h7777);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sp_issue_unit.md
# sp_issue_unit

Single-lane issue/writeback sequencer for the SP core. It accepts one decoded instruction at a time over a valid/ready handshake and reads three operands from a local 16 x 16-bit register file. It drives the operands and the 4-bit opcode into the external combinational ALU, then writes the ALU result and predicate flag back. It is the producer and consumer end of the ALU's A/B/C/ALU_C -> ALU_OUT/P interface.

## Interface
Parameters:
- `WIDTH`, 16, datapath and register width.
- `MAX_OP`, 9, highest legal ALU opcode. Opcodes above it are illegal.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  unit can accept an instruction.
- `in_op`  in  4  ALU opcode.
- `in_rd`, `in_ra`, `in_rb`, `in_rc`  in  4 each  destination and source register indices.
- `in_pred`  in  1  predicated instruction (used only with `SP_ISSUE_PRED_EN`).
- `alu_a`, `alu_b`, `alu_c`  out  WIDTH each  operands to the ALU.
- `alu_ctrl`  out  4  opcode to the ALU.
- `alu_out`  in  WIDTH  ALU result.
- `alu_p`  in  1  ALU predicate flag.
- `host_we`  in  1  host register write enable.
- `host_addr`  in  4  host register write index.
- `host_data`  in  WIDTH  host register write data.
- `dbg_addr`  in  4  combinational read index.
- `dbg_data`  out  WIDTH  combinational read data.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `err`  out  1  one-cycle pulse, coincident with `done`, when the retiring opcode is illegal.
- `p_flag`  out  1  architectural predicate register.

## Operation
- The FSM has four states: IDLE, READ, EXEC, WB.
- IDLE:
  - `in_ready` = 1.
  - When `in_valid` is high, latch op, rd, ra, rb, rc and pred, then go to READ.
- READ: register `alu_a` = R[ra], `alu_b` = R[rb], `alu_c` = R[rc] and `alu_ctrl` = op, then go to EXEC.
- EXEC:
  - `alu_*` outputs hold their values.
  - Sample `alu_out` and `alu_p` at the end of the cycle, then go to WB.
- WB:
  - For a legal op, write R[rd] <= sampled result and p_flag <= sampled P.
  - Pulse `done` (and `err` if the op is illegal), then go to IDLE.
- R0 reads as zero. Writes to R0, from WB or host, are discarded.
- Illegal opcode (op > MAX_OP): the instruction still flows through READ and EXEC, but WB writes neither R[rd] nor p_flag, and `err` = 1.
- Host write:
  - Takes effect in any state.
  - If a host write and a WB write target the same register in the same cycle, WB wins.
  - A host write to a source register during READ is not seen; READ samples the pre-edge value.
- `dbg_data` = R[dbg_addr], combinational, showing pre-edge contents.

## Timing
- An instruction accepted at edge k is in READ during k+1, EXEC during k+2 and WB during k+3. `done` is high during cycle k+3, and the register write is visible from k+4.
- `in_ready` is high only in IDLE, so the next accept comes at edge k+4 at the earliest. Throughput is one instruction per 4 cycles.
- `alu_*` outputs are stable from the start of EXEC to the end of EXEC. The ALU path is combinational and must settle within one cycle.
- Reset values:
  - state = IDLE, `in_ready` = 1.
  - `alu_a`/`alu_b`/`alu_c` = 0, `alu_ctrl` = 0 (CLEAR).
  - `done` = 0, `err` = 0, `p_flag` = 0.
  - All registers = 0.
- Reset asserted mid-instruction: the instruction is abandoned with no writeback and no `done`. The unit is in IDLE on the cycle after reset deasserts.

## Configuration
- `SP_ISSUE_PRED_EN` defined:
  - An instruction with `in_pred` = 1 executes its WB only if `p_flag` = 1 at the time the instruction is accepted.
  - If `p_flag` = 0, the instruction still passes through all four states and pulses `done`, but writes nothing.
- `SP_ISSUE_PRED_EN` undefined: `in_pred` is ignored and every legal instruction writes back.

## Test plan
- Operand routing:
  - Host-write R1=0x0019, R2=0x0002, R3=0x0005.
  - Issue op=4, rd=4, ra=1, rb=2, rc=3.
  - Required in EXEC: `alu_a`=0x0019, `alu_b`=0x0002, `alu_c`=0x0005, `alu_ctrl`=4.
  - Bench drives `alu_out`=0x00AB, `alu_p`=1. Required: R4=0x00AB, `p_flag`=1, `done` exactly 3 cycles after accept.
- Illegal opcode:
  - R5=0x1234, issue op=12, rd=5.
  - Required: `done`=`err`=1 in WB, R5 stays 0x1234, `p_flag` unchanged.
- R0 and collision:
  - Issue rd=0 with `alu_out`=0xFFFF. Required: R0 reads 0.
  - Issue rd=6 with `alu_out`=0x0001 and a host write of R6=0x5555 in the WB cycle. Required: R6=0x0001.
- Back-to-back:
  - Hold `in_valid`=1 with 3 instructions.
  - Required: accepts 4 cycles apart, `in_ready` low for exactly 3 cycles after each accept.
- Reset mid-op:
  - Assert `reset` during EXEC of rd=7.
  - Required: no `done`, R7=0, all outputs at reset values, next accept succeeds.
- Predication (`SP_ISSUE_PRED_EN` defined):
  - With `p_flag`=0, a pred=1 instruction to R8 leaves R8=0.
  - After a legal op sets `p_flag`=1, the same instruction writes R8.
